// File: rtl/sp_ram_arbiter.sv
// Round-robin request/grant arbiter for the shared single-port fft0 BSRAM.
// Three requesters (0 demod, 1 fft1024, 2 ofdm) take turns owning the RAM.
// Every handover inserts a drain gap so the last read completes. An optional
// watchdog revokes a grant that is held for too long.
module sp_ram_arbiter #(
    parameter int AW           = 11,
    parameter int DW           = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int MAX_HOLD     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      req,
    output logic [2:0]      gnt,
    input  logic [2:0]      oce_i,
    input  logic [2:0]      ce_i,
    input  logic [2:0]      wre_i,
    input  logic [3*AW-1:0] ad_i,
    input  logic [3*DW-1:0] din_i,
    output logic            ram_oce,
    output logic            ram_ce,
    output logic            ram_wre,
    output logic [AW-1:0]   ram_ad,
    output logic [DW-1:0]   ram_din,
    output logic [1:0]      owner,
    output logic            busy,
    output logic            timeout_err,
    output logic [1:0]      err_owner
);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t        state, state_n;
    logic [2:0]    gnt_n, mask, mask_n, eff;
    logic [1:0]    owner_n, rr_last, rr_n, pick, eo_n;
    logic [15:0]   hold, hold_n, dcnt, dcnt_n;
    logic          to_n, found;
    logic [AW-1:0] last_ad, last_ad_n, own_ad;
    logic [DW-1:0] last_din, last_din_n, own_din;
    logic          own_ce, own_wre, own_oce, own_req, own_gnt;

    assign busy = (state != IDLE);
    assign eff  = req & ~mask;

    // Select the current owner's interface signals (none while owner is 3).
    always_comb begin
        own_ce  = 1'b0;
        own_wre = 1'b0;
        own_oce = 1'b0;
        own_req = 1'b0;
        own_gnt = 1'b0;
        own_ad  = '0;
        own_din = '0;
        for (int i = 0; i < 3; i++) begin
            if (owner == 2'(i)) begin
                own_ce  = ce_i[i];
                own_wre = wre_i[i];
                own_oce = oce_i[i];
                own_req = req[i];
                own_gnt = gnt[i];
                own_ad  = ad_i[i*AW +: AW];
                own_din = din_i[i*DW +: DW];
            end
        end
    end

    // Round-robin pick: first effective request after the last winner.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            int c;
            c = (int'(rr_last) + j) % 3;
            if (!found && eff[c]) begin
                pick  = 2'(c);
                found = 1'b1;
            end
        end
    end

    // Next-state logic for grant, drain and watchdog bookkeeping.
    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        owner_n    = owner;
        rr_n       = rr_last;
        hold_n     = hold;
        dcnt_n     = dcnt;
        mask_n     = mask & req;
        to_n       = 1'b0;
        eo_n       = err_owner;
        last_ad_n  = last_ad;
        last_din_n = last_din;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n   = 3'b001 << pick;
                    owner_n = pick;
                    rr_n    = pick;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                hold_n     = (hold == 16'hFFFF) ? hold : hold + 16'd1;
                last_ad_n  = own_ad;
                last_din_n = own_din;
                if (!own_req || (MAX_HOLD != 0 && hold == 16'(MAX_HOLD - 1))) begin
                    gnt_n   = '0;
                    dcnt_n  = '0;
                    state_n = (DRAIN_CYCLES > 0) ? DRAIN : IDLE;
                    // A release on the watchdog cycle is a normal release.
                    if (own_req) begin
                        to_n          = 1'b1;
                        eo_n          = owner;
                        mask_n[owner] = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (dcnt == 16'(DRAIN_CYCLES - 1)) state_n = IDLE;
                else                                dcnt_n  = dcnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; reset aborts any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            owner       <= 2'd3;
            rr_last     <= 2'd2;
            hold        <= '0;
            dcnt        <= '0;
            mask        <= '0;
            timeout_err <= 1'b0;
            err_owner   <= 2'd0;
            last_ad     <= '0;
            last_din    <= '0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            owner       <= owner_n;
            rr_last     <= rr_n;
            hold        <= hold_n;
            dcnt        <= dcnt_n;
            mask        <= mask_n;
            timeout_err <= to_n;
            err_owner   <= eo_n;
            last_ad     <= last_ad_n;
            last_din    <= last_din_n;
        end
    end

    // RAM port mux; drain keeps oce high and the address stable for the last read.
    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_oce = 1'b0;
        ram_ad  = '0;
        ram_din = '0;
        case (state)
            GRANT: begin
                ram_ce  = own_ce & own_gnt;
                ram_wre = own_wre & own_gnt;
                ram_oce = own_oce & own_gnt;
                ram_ad  = own_ad;
                ram_din = own_din;
            end
            DRAIN: begin
                ram_oce = 1'b1;
                ram_ad  = last_ad;
                ram_din = last_din;
            end
            default: ;
        endcase
    end

endmodule
